// File: rtl/reg_sched_pkg.sv
// Shared parameters for the register scoreboard: register-file geometry
// and pending-write counter limits.
package reg_sched_pkg;

    localparam int NUM_REGS   = 16;
    localparam int ADDR_W     = 4;
    localparam int CNT_W      = 2;
    localparam int INFLIGHT_W = 6;

    localparam logic [ADDR_W-1:0] ZERO_REG = 4'd0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = 2'd3;

endpackage : reg_sched_pkg

// File: rtl/reg_pend_counter.sv
// Pending-write counter for one architectural register: counts issued but
// not yet retired writes and flags a retire with nothing outstanding.
module reg_pend_counter
    import reg_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nonzero,
    output logic             is_one,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count; a simultaneous issue and retire cancel out.
    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            2'b01: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    underflow = 1'b1;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = (cnt_q != {CNT_W{1'b0}});
    assign is_one  = (cnt_q == CNT_W'(1));
    assign full    = (cnt_q == CNT_MAX);

endmodule : reg_pend_counter

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes per register and stalls
// issue on read-after-write and pending-write capacity hazards.
module reg_scoreboard
    import reg_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_W-1:0]     issue_src1,
    input  logic                  issue_use1,
    input  logic [ADDR_W-1:0]     issue_src2,
    input  logic                  issue_use2,
    input  logic                  issue_wr,
    input  logic [ADDR_W-1:0]     issue_dst,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_dst,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy,
    output logic [INFLIGHT_W-1:0] inflight,
    output logic                  err
);

    logic [CNT_W-1:0]    cnt_s [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] nonzero_s;
    logic [NUM_REGS-1:0] is_one_s;
    logic [NUM_REGS-1:0] full_s;
    logic [NUM_REGS-1:0] underflow_s;
    logic [NUM_REGS-1:0] inc_s;
    logic [NUM_REGS-1:0] dec_s;
    logic                haz1_s;
    logic                haz2_s;
    logic                cap_s;
    logic                accept_s;
    logic                err_q;

    // Register 0 is hardwired zero and is never tracked.
    assign nonzero_s[0]   = 1'b0;
    assign is_one_s[0]    = 1'b0;
    assign full_s[0]      = 1'b0;
    assign underflow_s[0] = 1'b0;
    assign inc_s[0]       = 1'b0;
    assign dec_s[0]       = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        assign inc_s[i] = accept_s && (issue_dst == ADDR_W'(i));
        assign dec_s[i] = wb_valid && (wb_dst == ADDR_W'(i));

        reg_pend_counter u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_s[i]),
            .dec       (dec_s[i]),
            .cnt       (cnt_s[i]),
            .nonzero   (nonzero_s[i]),
            .is_one    (is_one_s[i]),
            .full      (full_s[i]),
            .underflow (underflow_s[i])
        );
    end

    // Hazards; a same-cycle retire of the last pending write bypasses.
    always_comb begin
        haz1_s = issue_use1 && (issue_src1 != ZERO_REG) && nonzero_s[issue_src1]
                 && !(wb_valid && (wb_dst == issue_src1) && is_one_s[issue_src1]);
        haz2_s = issue_use2 && (issue_src2 != ZERO_REG) && nonzero_s[issue_src2]
                 && !(wb_valid && (wb_dst == issue_src2) && is_one_s[issue_src2]);
        cap_s  = issue_wr && (issue_dst != ZERO_REG) && full_s[issue_dst]
                 && !(wb_valid && (wb_dst == issue_dst));
        if (issue_valid) begin
            stall = haz1_s || haz2_s || cap_s;
        end else begin
            stall = 1'b0;
        end
    end

    assign accept_s = issue_valid && !stall && issue_wr && (issue_dst != ZERO_REG);

    // Total outstanding writes across all tracked registers.
    always_comb begin
        inflight = {INFLIGHT_W{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            inflight = inflight + INFLIGHT_W'(cnt_s[i]);
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (|underflow_s) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign busy = nonzero_s;
    assign err  = err_q;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_use1, issue_use2, issue_wr, wb_valid;
    logic [3:0] issue_src1, issue_src2, issue_dst, wb_dst;
    logic        stall;
    logic [15:0] busy;
    logic [5:0]  inflight;
    logic        err;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;
    int  m_cnt [16];
    bit  m_err;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_src1(issue_src1), .issue_use1(issue_use1),
        .issue_src2(issue_src2), .issue_use2(issue_use2), .issue_wr(issue_wr),
        .issue_dst(issue_dst), .wb_valid(wb_valid), .wb_dst(wb_dst),
        .stall(stall), .busy(busy), .inflight(inflight), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit src_blocked(input bit use_it, input int r);
        if (!use_it || r == 0 || m_cnt[r] == 0) return 1'b0;
        if (wb_valid && int'(wb_dst) == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        bit cap;
        if (!issue_valid) return 1'b0;
        cap = issue_wr && issue_dst != 4'd0 && m_cnt[issue_dst] == 3
              && !(wb_valid && wb_dst == issue_dst);
        return src_blocked(issue_use1, int'(issue_src1))
            || src_blocked(issue_use2, int'(issue_src2)) || cap;
    endfunction

    function automatic logic [15:0] m_busy();
        logic [15:0] b = 16'd0;
        for (int i = 1; i < 16; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    function automatic int m_total();
        int s = 0;
        for (int i = 1; i < 16; i++) s += m_cnt[i];
        return s;
    endfunction

    // Advance one clock and apply the architectural effect of this cycle's inputs.
    task automatic tick();
        bit acc;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_err = 1'b0;
        end else begin
            acc = issue_valid && !m_stall() && issue_wr && issue_dst != 4'd0;
            if (acc) m_cnt[issue_dst]++;
            if (wb_valid && wb_dst != 4'd0) begin
                if (m_cnt[wb_dst] == 0) m_err = 1'b1;
                else m_cnt[wb_dst]--;
            end
        end
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_use1 = 1'b0; issue_use2 = 1'b0; issue_wr = 1'b0;
        issue_src1 = 4'd0;  issue_src2 = 4'd0; issue_dst = 4'd0;
        wb_valid = 1'b0;    wb_dst = 4'd0;
    endtask

    task automatic issue(input logic [3:0] s1, input bit u1, input bit wr, input logic [3:0] d);
        issue_valid = 1'b1; issue_src1 = s1; issue_use1 = u1;
        issue_src2 = 4'd0;  issue_use2 = 1'b0; issue_wr = wr; issue_dst = d;
    endtask

    // Every cycle outputs are compared with the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, m_stall()});
            chk("busy", {16'd0, busy}, {16'd0, m_busy()});
            chk("inflight", {26'd0, inflight}, m_total());
            chk("err", {31'd0, err}, {31'd0, m_err});
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset busy", {16'd0, busy}, 32'h0);
        chk("reset inflight", {26'd0, inflight}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);

        issue(4'd0, 1'b0, 1'b1, 4'd2);
        #1 chk("wr2 stall", {31'd0, stall}, 32'd0);
        tick(); idle(); #1;
        chk("wr2 busy", {16'd0, busy}, 32'h0004);
        chk("wr2 inflight", {26'd0, inflight}, 32'd1);

        issue(4'd2, 1'b1, 1'b0, 4'd0);
        #1 chk("raw stall", {31'd0, stall}, 32'd1);
        wb_valid = 1'b1; wb_dst = 4'd2;
        #1 chk("bypass stall", {31'd0, stall}, 32'd0);
        tick(); idle(); #1;
        chk("bypass busy", {16'd0, busy}, 32'h0);

        for (int k = 0; k < 3; k++) begin
            issue(4'd0, 1'b0, 1'b1, 4'd7);
            tick();
        end
        idle(); #1;
        chk("fill7 inflight", {26'd0, inflight}, 32'd3);
        chk("fill7 busy", {16'd0, busy}, 32'h0080);
        issue(4'd0, 1'b0, 1'b1, 4'd7);
        #1 chk("cap stall", {31'd0, stall}, 32'd1);
        wb_valid = 1'b1; wb_dst = 4'd7;
        #1 chk("cap bypass stall", {31'd0, stall}, 32'd0);
        tick(); idle(); #1;
        chk("cap keep3", {26'd0, inflight}, 32'd3);
        wb_valid = 1'b1; wb_dst = 4'd7;
        tick(); tick(); tick(); idle();

        issue(4'd0, 1'b1, 1'b1, 4'd0);
        #1 chk("zero stall", {31'd0, stall}, 32'd0);
        tick(); idle(); #1;
        chk("zero busy", {16'd0, busy}, 32'h0);
        chk("zero inflight", {26'd0, inflight}, 32'd0);

        wb_valid = 1'b1; wb_dst = 4'd5;
        tick(); idle(); #1;
        chk("underflow err", {31'd0, err}, 32'd1);
        tick(); tick(); #1;
        chk("err sticky", {31'd0, err}, 32'd1);
        chk("underflow busy", {16'd0, busy}, 32'h0);

        issue(4'd0, 1'b0, 1'b1, 4'd4); tick();
        issue(4'd0, 1'b0, 1'b1, 4'd8); tick();
        idle(); #1;
        chk("fill48 inflight", {26'd0, inflight}, 32'd2);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("rst busy", {16'd0, busy}, 32'h0);
        chk("rst inflight", {26'd0, inflight}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        issue(4'd4, 1'b1, 1'b0, 4'd0);
        #1 chk("rst stall", {31'd0, stall}, 32'd0);
        tick(); idle();

        // Randomized traffic over a few registers to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            issue_valid = ($urandom_range(0, 9) < 8);
            issue_src1  = 4'($urandom_range(0, 4));
            issue_use1  = 1'($urandom_range(0, 1));
            issue_src2  = 4'($urandom_range(0, 4));
            issue_use2  = 1'($urandom_range(0, 1));
            issue_wr    = ($urandom_range(0, 3) != 0);
            issue_dst   = 4'($urandom_range(0, 4));
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_dst      = 4'($urandom_range(0, 4));
            tick();
        end

        idle(); rst = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_scoreboard
